// File: rtl/reg_f_pkg.sv
// Shared definitions for the register-file access arbiter: owner states,
// requester IDs and the external-port select value.
package reg_f_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOCK_A = 2'd1,
        LOCK_B = 2'd2
    } owner_e;

    localparam logic REQ_A = 1'b0;
    localparam logic REQ_B = 1'b1;

    // Wide enough for MAX_BURST up to 15.
    localparam int BURST_W = 4;

    // All-ones select addresses the register file's external port; slice to SELW.
    localparam logic [15:0] PORT_SEL = '1;

endpackage

// File: rtl/reg_f_arb_rr_arb2.sv
// Two-way round-robin picker: the requester not granted last wins a tie.
// Holds the last-granted pointer, updated on every grant.
module rr_arb2
    import reg_f_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] i_req,
    input  logic       i_upd,
    input  logic       i_upd_id,
    output logic       o_pick_vld,
    output logic       o_pick_id
);

    logic r_last;

    always_comb begin
        o_pick_vld = i_req[REQ_A] | i_req[REQ_B];
        o_pick_id  = REQ_A;
        if (i_req[REQ_A] && i_req[REQ_B]) begin
            o_pick_id = ~r_last;
        end else if (i_req[REQ_B]) begin
            o_pick_id = REQ_B;
        end
    end

    // Resetting to B makes A the winner of the first contention.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last <= REQ_B;
        end else if (i_upd) begin
            r_last <= i_upd_id;
        end
    end

endmodule

// File: rtl/reg_f_arb.sv
// Arbiter/sequencer sharing the register-file access path between the core
// (A) and the debug/loader port (B), with round-robin and bounded locked bursts.
module reg_f_arb
    import reg_f_pkg::*;
#(
    parameter  int WIDTH     = 8,
    parameter  int SIZE      = 9,
    parameter  int MAX_BURST = 4,
    localparam int SELW      = $clog2(SIZE)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a_req,
    input  logic             b_req,
    input  logic             a_we,
    input  logic             b_we,
    input  logic             a_lock,
    input  logic             b_lock,
    input  logic [SELW-1:0]  a_sel,
    input  logic [SELW-1:0]  b_sel,
    input  logic [WIDTH-1:0] a_wdata,
    input  logic [WIDTH-1:0] b_wdata,
    output logic             a_gnt,
    output logic             b_gnt,
    output logic [WIDTH-1:0] a_rdata,
    output logic [WIDTH-1:0] b_rdata,
    output logic             a_rvalid,
    output logic             b_rvalid,
    output logic             rf_en,
    output logic [SELW-1:0]  rf_sel,
    output logic [WIDTH-1:0] rf_in,
    input  logic [WIDTH-1:0] rf_out
);

    localparam logic [BURST_W-1:0] MAX_B = BURST_W'(MAX_BURST);

    function automatic logic [BURST_W-1:0] burst_sat_inc(input logic [BURST_W-1:0] cnt);
        if (cnt >= MAX_B) begin
            return MAX_B;
        end
        return cnt + BURST_W'(1);
    endfunction

    owner_e             r_state;
    owner_e             w_state_nxt;
    logic [BURST_W-1:0] r_burst;
    logic [BURST_W-1:0] w_burst_nxt;
    logic               w_hold_a;
    logic               w_hold_b;
    logic               w_pick_vld;
    logic               w_pick_id;
    logic               w_gnt_a;
    logic               w_gnt_b;
    logic               w_any_gnt;
    logic               w_gnt_id;
    logic [SELW-1:0]    w_sel;
    logic [WIDTH-1:0]   w_wdata;
    logic               w_we;
    logic [SELW-1:0]    r_rf_sel;
    logic [WIDTH-1:0]   r_a_rdata_p1;
    logic [WIDTH-1:0]   r_b_rdata_p1;
    logic               r_a_rvalid_p1;
    logic               r_b_rvalid_p1;

    rr_arb2 u_rr (
        .clk        (clk),
        .rst        (rst),
        .i_req      ({b_req, a_req}),
        .i_upd      (w_any_gnt),
        .i_upd_id   (w_gnt_id),
        .o_pick_vld (w_pick_vld),
        .o_pick_id  (w_pick_id)
    );

    // Owner keeps the path while under the burst limit, or past it if nobody waits.
    always_comb begin
        w_hold_a    = (r_state == LOCK_A) && a_req && ((r_burst < MAX_B) || !b_req);
        w_hold_b    = (r_state == LOCK_B) && b_req && ((r_burst < MAX_B) || !a_req);
        w_gnt_a     = 1'b0;
        w_gnt_b     = 1'b0;
        w_state_nxt = IDLE;
        w_burst_nxt = '0;
        if (!rst) begin
            if (w_hold_a) begin
                w_gnt_a = 1'b1;
            end else if (w_hold_b) begin
                w_gnt_b = 1'b1;
            end else if (w_pick_vld) begin
                w_gnt_a = (w_pick_id == REQ_A);
                w_gnt_b = (w_pick_id == REQ_B);
            end
        end
        if (w_gnt_a) begin
            w_state_nxt = a_lock ? LOCK_A : IDLE;
            w_burst_nxt = (r_state == LOCK_A) ? burst_sat_inc(r_burst) : BURST_W'(1);
        end else if (w_gnt_b) begin
            w_state_nxt = b_lock ? LOCK_B : IDLE;
            w_burst_nxt = (r_state == LOCK_B) ? burst_sat_inc(r_burst) : BURST_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_burst <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_burst <= w_burst_nxt;
        end
    end

    assign w_any_gnt = w_gnt_a | w_gnt_b;
    assign w_gnt_id  = w_gnt_b ? REQ_B : REQ_A;
    assign w_sel     = w_gnt_b ? b_sel   : a_sel;
    assign w_wdata   = w_gnt_b ? b_wdata : a_wdata;
    assign w_we      = w_gnt_b ? b_we    : a_we;

    assign a_gnt  = w_gnt_a;
    assign b_gnt  = w_gnt_b;
    assign rf_en  = w_any_gnt & w_we;
    assign rf_sel = w_any_gnt ? w_sel : r_rf_sel;
    assign rf_in  = w_wdata;

    // p0 -> p1: capture read data at the edge ending the grant cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rf_sel      <= '0;
            r_a_rdata_p1  <= '0;
            r_b_rdata_p1  <= '0;
            r_a_rvalid_p1 <= 1'b0;
            r_b_rvalid_p1 <= 1'b0;
        end else begin
            if (w_any_gnt) begin
                r_rf_sel <= w_sel;
            end
            r_a_rvalid_p1 <= w_gnt_a & ~a_we;
            r_b_rvalid_p1 <= w_gnt_b & ~b_we;
            if (w_gnt_a && !a_we) begin
                r_a_rdata_p1 <= rf_out;
            end
            if (w_gnt_b && !b_we) begin
                r_b_rdata_p1 <= rf_out;
            end
        end
    end

    assign a_rdata  = r_a_rdata_p1;
    assign b_rdata  = r_b_rdata_p1;
    assign a_rvalid = r_a_rvalid_p1;
    assign b_rvalid = r_b_rvalid_p1;

endmodule

// File: tb/tb_reg_f_arb.sv
// Directed-vector bench for reg_f_arb with a small behavioural register file.
module tb_reg_f_arb;
    import reg_f_pkg::*;

    localparam int WIDTH = 8;
    localparam int SIZE  = 9;
    localparam int SELW  = 4;

    logic             clk;
    logic             rst;
    logic             a_req, b_req, a_we, b_we, a_lock, b_lock;
    logic [SELW-1:0]  a_sel, b_sel;
    logic [WIDTH-1:0] a_wdata, b_wdata;
    logic             a_gnt, b_gnt, a_rvalid, b_rvalid;
    logic [WIDTH-1:0] a_rdata, b_rdata;
    logic             rf_en;
    logic [SELW-1:0]  rf_sel;
    logic [WIDTH-1:0] rf_in, rf_out;

    int n_cmp;
    int n_bad;

    reg_f_arb #(.WIDTH(WIDTH), .SIZE(SIZE), .MAX_BURST(4)) dut (
        .clk(clk), .rst(rst),
        .a_req(a_req), .b_req(b_req), .a_we(a_we), .b_we(b_we),
        .a_lock(a_lock), .b_lock(b_lock), .a_sel(a_sel), .b_sel(b_sel),
        .a_wdata(a_wdata), .b_wdata(b_wdata),
        .a_gnt(a_gnt), .b_gnt(b_gnt), .a_rdata(a_rdata), .b_rdata(b_rdata),
        .a_rvalid(a_rvalid), .b_rvalid(b_rvalid),
        .rf_en(rf_en), .rf_sel(rf_sel), .rf_in(rf_in), .rf_out(rf_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file model: writes on en, combinational read; out-of-range selects ignored.
    logic [WIDTH-1:0] regs [SIZE];
    initial for (int i = 0; i < SIZE; i++) regs[i] = '0;
    always @(posedge clk) if (rf_en && rf_sel < SELW'(SIZE)) regs[rf_sel] <= rf_in;
    assign rf_out = (rf_sel < SELW'(SIZE)) ? regs[rf_sel] : '0;

    typedef struct {
        logic       rst;
        logic       ar, aw, al;
        logic [3:0] as;
        logic [7:0] ad;
        logic       br, bw, bl;
        logic [3:0] bs;
        logic [7:0] bd;
        logic       ga, gb, en;
        logic [3:0] sel;
        logic       av, bv;
        logic [7:0] ard, brd;
    } vec_t;

    function automatic vec_t mk(
        input logic rs,
        input logic ar, input logic aw, input logic al, input logic [3:0] as, input logic [7:0] ad,
        input logic br, input logic bw, input logic bl, input logic [3:0] bs, input logic [7:0] bd,
        input logic ga, input logic gb, input logic en, input logic [3:0] sel,
        input logic av, input logic bv, input logic [7:0] ard, input logic [7:0] brd);
        vec_t v;
        v.rst = rs;
        v.ar = ar; v.aw = aw; v.al = al; v.as = as; v.ad = ad;
        v.br = br; v.bw = bw; v.bl = bl; v.bs = bs; v.bd = bd;
        v.ga = ga; v.gb = gb; v.en = en; v.sel = sel;
        v.av = av; v.bv = bv; v.ard = ard; v.brd = brd;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic apply(input vec_t v, input string nm);
        rst = v.rst;
        a_req = v.ar; a_we = v.aw; a_lock = v.al; a_sel = v.as; a_wdata = v.ad;
        b_req = v.br; b_we = v.bw; b_lock = v.bl; b_sel = v.bs; b_wdata = v.bd;
        #1;
        chk({nm, ".a_gnt"},    32'(a_gnt),    32'(v.ga));
        chk({nm, ".b_gnt"},    32'(b_gnt),    32'(v.gb));
        chk({nm, ".rf_en"},    32'(rf_en),    32'(v.en));
        chk({nm, ".rf_sel"},   32'(rf_sel),   32'(v.sel));
        chk({nm, ".a_rvalid"}, 32'(a_rvalid), 32'(v.av));
        chk({nm, ".b_rvalid"}, 32'(b_rvalid), 32'(v.bv));
        chk({nm, ".a_rdata"},  32'(a_rdata),  32'(v.ard));
        chk({nm, ".b_rdata"},  32'(b_rdata),  32'(v.brd));
        @(posedge clk);
        #1;
    endtask

    vec_t tbl [26];
    logic [3:0] psel;

    initial begin
        n_cmp = 0;
        n_bad = 0;
        psel  = PORT_SEL[3:0];

        //          rs  ar aw al as   ad     br bw bl bs  bd     ga gb en sel   av bv ard    brd
        tbl[0]  = mk(1, 1, 1, 0, 3, 8'h11,  1, 0, 0, 2, 8'h00,  0, 0, 0, 0,    0, 0, 8'h00, 8'h00); // gnt blocked in reset
        tbl[1]  = mk(0, 1, 1, 0, 3, 8'h5A,  0, 0, 0, 0, 8'h00,  1, 0, 1, 3,    0, 0, 8'h00, 8'h00); // A write
        tbl[2]  = mk(0, 0, 0, 0, 0, 8'h00,  1, 0, 0, 3, 8'h00,  0, 1, 0, 3,    0, 0, 8'h00, 8'h00); // B read
        tbl[3]  = mk(0, 0, 0, 0, 0, 8'h00,  0, 0, 0, 0, 8'h00,  0, 0, 0, 3,    0, 1, 8'h00, 8'h5A);
        tbl[4]  = mk(0, 0, 0, 0, 0, 8'h00,  0, 0, 0, 0, 8'h00,  0, 0, 0, 3,    0, 0, 8'h00, 8'h5A);
        tbl[5]  = mk(0, 1, 1, 0, 1, 8'h01,  1, 1, 0, 2, 8'h02,  1, 0, 1, 1,    0, 0, 8'h00, 8'h5A); // contention
        tbl[6]  = mk(0, 1, 1, 0, 1, 8'h01,  1, 1, 0, 2, 8'h02,  0, 1, 1, 2,    0, 0, 8'h00, 8'h5A);
        tbl[7]  = mk(0, 1, 1, 0, 1, 8'h01,  1, 1, 0, 2, 8'h02,  1, 0, 1, 1,    0, 0, 8'h00, 8'h5A);
        tbl[8]  = mk(0, 1, 1, 0, 1, 8'h01,  1, 1, 0, 2, 8'h02,  0, 1, 1, 2,    0, 0, 8'h00, 8'h5A);
        tbl[9]  = mk(0, 1, 0, 1, 1, 8'h00,  1, 0, 0, 2, 8'h00,  1, 0, 0, 1,    0, 0, 8'h00, 8'h5A); // A locked burst
        tbl[10] = mk(0, 1, 0, 1, 1, 8'h00,  1, 0, 0, 2, 8'h00,  1, 0, 0, 1,    1, 0, 8'h01, 8'h5A);
        tbl[11] = mk(0, 1, 0, 1, 1, 8'h00,  1, 0, 0, 2, 8'h00,  1, 0, 0, 1,    1, 0, 8'h01, 8'h5A);
        tbl[12] = mk(0, 1, 0, 1, 1, 8'h00,  1, 0, 0, 2, 8'h00,  1, 0, 0, 1,    1, 0, 8'h01, 8'h5A);
        tbl[13] = mk(0, 1, 0, 1, 1, 8'h00,  1, 0, 0, 2, 8'h00,  0, 1, 0, 2,    1, 0, 8'h01, 8'h5A); // limit hit
        tbl[14] = mk(0, 1, 0, 1, 1, 8'h00,  1, 0, 0, 2, 8'h00,  1, 0, 0, 1,    0, 1, 8'h01, 8'h02);
        tbl[15] = mk(0, 0, 0, 0, 0, 8'h00,  1, 0, 0, 2, 8'h00,  0, 1, 0, 2,    1, 0, 8'h01, 8'h02); // release
        tbl[16] = mk(0, 1, 1, 0, psel, 8'hC3, 0, 0, 0, 0, 8'h00, 1, 0, 1, psel, 0, 1, 8'h01, 8'h02); // port write
        tbl[17] = mk(0, 0, 0, 0, 0, 8'h00,  0, 0, 0, 0, 8'h00,  0, 0, 0, psel, 0, 0, 8'h01, 8'h02);
        tbl[18] = mk(0, 0, 0, 0, 0, 8'h00,  0, 0, 0, 0, 8'h00,  0, 0, 0, psel, 0, 0, 8'h01, 8'h02);
        tbl[19] = mk(0, 0, 0, 0, 0, 8'h00,  1, 0, 1, 3, 8'h00,  0, 1, 0, 3,    0, 0, 8'h01, 8'h02); // B locked, A idle
        tbl[20] = mk(0, 0, 0, 0, 0, 8'h00,  1, 0, 1, 3, 8'h00,  0, 1, 0, 3,    0, 1, 8'h01, 8'h5A);
        tbl[21] = mk(0, 0, 0, 0, 0, 8'h00,  1, 0, 1, 3, 8'h00,  0, 1, 0, 3,    0, 1, 8'h01, 8'h5A);
        tbl[22] = mk(0, 0, 0, 0, 0, 8'h00,  1, 0, 1, 3, 8'h00,  0, 1, 0, 3,    0, 1, 8'h01, 8'h5A);
        tbl[23] = mk(0, 0, 0, 0, 0, 8'h00,  1, 0, 1, 3, 8'h00,  0, 1, 0, 3,    0, 1, 8'h01, 8'h5A); // past limit, nobody waits
        tbl[24] = mk(0, 1, 1, 0, 4, 8'h44,  1, 0, 1, 3, 8'h00,  1, 0, 1, 4,    0, 1, 8'h01, 8'h5A); // saturated, A wins
        tbl[25] = mk(0, 0, 0, 0, 0, 8'h00,  1, 0, 1, 3, 8'h00,  0, 1, 0, 3,    0, 0, 8'h01, 8'h5A);

        rst = 1'b1;
        a_req = 0; a_we = 0; a_lock = 0; a_sel = '0; a_wdata = '0;
        b_req = 0; b_we = 0; b_lock = 0; b_sel = '0; b_wdata = '0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 26; i++) begin
            apply(tbl[i], $sformatf("v%0d", i));
        end

        // Reset in the middle of a B locked read burst.
        apply(mk(0, 0, 0, 0, 0, 8'h00, 1, 0, 1, 2, 8'h00, 0, 1, 0, 2, 0, 1, 8'h01, 8'h5A), "mid_rst.h1");
        apply(mk(0, 0, 0, 0, 0, 8'h00, 1, 0, 1, 2, 8'h00, 0, 1, 0, 2, 0, 1, 8'h01, 8'h02), "mid_rst.h2");
        apply(mk(1, 1, 0, 0, 4, 8'h00, 1, 0, 1, 2, 8'h00, 0, 0, 0, 2, 0, 1, 8'h01, 8'h02), "mid_rst.h3");
        apply(mk(0, 1, 0, 0, 4, 8'h00, 1, 0, 1, 2, 8'h00, 1, 0, 0, 4, 0, 0, 8'h00, 8'h00), "mid_rst.h4");
        apply(mk(0, 1, 0, 0, 4, 8'h00, 1, 0, 1, 2, 8'h00, 0, 1, 0, 2, 1, 0, 8'h44, 8'h00), "mid_rst.h5");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
